mem_arbiter: RTL and testbench

// Shares the single 4-cycle-latency unified memory port between the I-cache and D-cache fill FSMs.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/arb_drain_counter.sv | 31 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and arithmetic helpers for the unified memory-port arbiter.
package mem_arbiter_pkg;

    localparam int MEM_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10,
        ST_DRAIN = 2'b11
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // 4-bit carry-lookahead sum; carry-out is not needed by any user
    function automatic logic [3:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [2:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a[2:0] & b[2:0];
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return p ^ c;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side requests, memory-side controls and steered valids around the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic              i_mem_en;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_mem_en;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              mem_data_valid;
    logic              i_grant;
    logic              d_grant;
    logic              i_data_valid;
    logic              d_data_valid;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // arbiter side
    modport slave (
        input  i_req, i_mem_en, i_addr, d_req, d_mem_en, d_wr, d_addr, d_wdata, mem_data_valid,
        output i_grant, d_grant, i_data_valid, d_data_valid, mem_en, mem_wr, mem_addr, mem_wdata
    );

    // caches + memory side
    modport master (
        output i_req, i_mem_en, i_addr, d_req, d_mem_en, d_wr, d_addr, d_wdata, mem_data_valid,
        input  i_grant, d_grant, i_data_valid, d_data_valid, mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_drain_counter.sv
// Loadable down-counter timing the post-release drain window; saturates at zero.
module arb_drain_counter
    import mem_arbiter_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_r;

    // Count register: load wins over decrement; decrement adds all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && !zero) begin
            cnt_r <= W'(cla4(4'(cnt_r), 4'hF, 1'b0));
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Grants the single memory port to the I- or D-cache for whole transactions and
// steers returning read valids to the owner, including reads landing after release.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        state_r;
    arb_state_t        arb_next_s;
    owner_t            last_owner_r;
    logic              i_grant_r;
    logic              d_grant_r;
    logic              cnt_zero_s;
    logic              drain_load_s;
    logic              drain_dec_s;
    logic              mem_en_s;
    logic              mem_wr_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              i_dv_s;
    logic              d_dv_s;

    // Arbitration: a tie goes to whoever did not own the port last
    always_comb begin
        arb_next_s = ST_IDLE;
        if (bus.i_req && bus.d_req) begin
            arb_next_s = (last_owner_r == OWN_I) ? ST_GNT_D : ST_GNT_I;
        end else if (bus.i_req) begin
            arb_next_s = ST_GNT_I;
        end else if (bus.d_req) begin
            arb_next_s = ST_GNT_D;
        end else begin
            arb_next_s = ST_IDLE;
        end
    end

    assign drain_load_s = ((state_r == ST_GNT_I) && !bus.i_req) || ((state_r == ST_GNT_D) && !bus.d_req);
    assign drain_dec_s  = (state_r == ST_DRAIN);

    arb_drain_counter #(.W(CNT_W)) u_drain (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load_s),
        .load_val (DRAIN_LOAD),
        .dec      (drain_dec_s),
        .zero     (cnt_zero_s)
    );

    // Ownership FSM with registered grants
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_owner_r <= OWN_I;
            i_grant_r    <= 1'b0;
            d_grant_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r   <= arb_next_s;
                    i_grant_r <= (arb_next_s == ST_GNT_I);
                    d_grant_r <= (arb_next_s == ST_GNT_D);
                end
                ST_GNT_I: begin
                    if (!bus.i_req) begin
                        state_r      <= ST_DRAIN;
                        last_owner_r <= OWN_I;
                        i_grant_r    <= 1'b0;
                    end else begin
                        state_r <= ST_GNT_I;
                    end
                end
                ST_GNT_D: begin
                    if (!bus.d_req) begin
                        state_r      <= ST_DRAIN;
                        last_owner_r <= OWN_D;
                        d_grant_r    <= 1'b0;
                    end else begin
                        state_r <= ST_GNT_D;
                    end
                end
                ST_DRAIN: begin
                    // Re-arbitrate straight out of the last drain cycle, no idle bubble
                    if (cnt_zero_s) begin
                        state_r   <= arb_next_s;
                        i_grant_r <= (arb_next_s == ST_GNT_I);
                        d_grant_r <= (arb_next_s == ST_GNT_D);
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    i_grant_r <= 1'b0;
                    d_grant_r <= 1'b0;
                end
            endcase
        end
    end

    // Memory-side mux and valid steering, quiet whenever nobody holds a grant
    always_comb begin
        mem_en_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        i_dv_s      = 1'b0;
        d_dv_s      = 1'b0;
        case (state_r)
            ST_GNT_I: begin
                mem_en_s   = bus.i_mem_en;
                mem_addr_s = bus.i_addr;
                i_dv_s     = bus.mem_data_valid;
            end
            ST_GNT_D: begin
                mem_en_s    = bus.d_mem_en;
                mem_wr_s    = bus.d_wr & bus.d_mem_en;
                mem_addr_s  = bus.d_addr;
                mem_wdata_s = bus.d_wdata;
                d_dv_s      = bus.mem_data_valid;
            end
            ST_DRAIN: begin
                if (last_owner_r == OWN_I) begin
                    i_dv_s = bus.mem_data_valid;
                end else begin
                    d_dv_s = bus.mem_data_valid;
                end
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    assign bus.i_grant      = i_grant_r;
    assign bus.d_grant      = d_grant_r;
    assign bus.mem_en       = mem_en_s;
    assign bus.mem_wr       = mem_wr_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = mem_wdata_s;
    assign bus.i_data_valid = i_dv_s;
    assign bus.d_data_valid = d_dv_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: who owns the port this cycle, when arbitration may next happen,
    // and until which cycle late read data belongs to the previous owner.
    int owner;      // -1 none, 0 I-cache, 1 D-cache
    int last;
    int free_at;
    int drain_end;
    int rq[$];      // cycles at which memory returns read data
    int n_idv;
    int n_ddv;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        bus.i_req = 1'b0; bus.i_mem_en = 1'b0; bus.i_addr = 16'h0000;
        bus.d_req = 1'b0; bus.d_mem_en = 1'b0; bus.d_wr = 1'b0;
        bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000; bus.mem_data_valid = 1'b0;
    endtask

    task automatic model_reset();
        owner = -1; last = 0; free_at = cyc; drain_end = -1; rq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle: caller has driven cache inputs just after the falling edge
    task automatic step();
        logic e_en, e_wr, e_idv, e_ddv;
        logic [15:0] e_addr, e_wd;
        bit drn;
        bus.mem_data_valid = (rq.size() > 0) && (rq[0] == cyc);
        if (bus.mem_data_valid) void'(rq.pop_front());
        #1;
        drn    = (owner < 0) && (cyc <= drain_end);
        e_en   = (owner == 0) ? bus.i_mem_en : (owner == 1) ? bus.d_mem_en : 1'b0;
        e_wr   = (owner == 1) && bus.d_wr && bus.d_mem_en;
        e_addr = (owner == 0) ? bus.i_addr : (owner == 1) ? bus.d_addr : 16'h0000;
        e_wd   = (owner == 1) ? bus.d_wdata : 16'h0000;
        e_idv  = bus.mem_data_valid && ((owner == 0) || (drn && last == 0));
        e_ddv  = bus.mem_data_valid && ((owner == 1) || (drn && last == 1));
        check_eq("i_grant", bus.i_grant, owner == 0);
        check_eq("d_grant", bus.d_grant, owner == 1);
        check_eq("mem_en", bus.mem_en, e_en);
        check_eq("mem_wr", bus.mem_wr, e_wr);
        check_eq("mem_addr", bus.mem_addr, e_addr);
        check_eq("mem_wdata", bus.mem_wdata, e_wd);
        check_eq("i_data_valid", bus.i_data_valid, e_idv);
        check_eq("d_data_valid", bus.d_data_valid, e_ddv);
        if (bus.mem_data_valid && owner < 0 && !drn) check_eq("mdv_in_idle", 32'd1, 32'd0);
        if (bus.i_data_valid) n_idv++;
        if (bus.d_data_valid) n_ddv++;
        if (e_en && !e_wr) rq.push_back(cyc + LAT);
        if (owner >= 0) begin
            if ((owner == 0 && !bus.i_req) || (owner == 1 && !bus.d_req)) begin
                last = owner; drain_end = cyc + LAT; free_at = cyc + LAT; owner = -1;
            end
        end else if (cyc >= free_at) begin
            if (bus.i_req && bus.d_req) owner = 1 - last;
            else if (bus.i_req)         owner = 0;
            else if (bus.d_req)         owner = 1;
            else                        owner = -1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_grant(input int who, input int maxc);
        int k;
        k = 0;
        while (((who == 0) ? bus.i_grant : bus.d_grant) !== 1'b1 && k < maxc) begin
            step();
            k++;
        end
        check_eq("wait_grant_timeout", (k < maxc), 32'd1);
    endtask

    initial begin
        int ileft, dleft;
        int seq[$];
        bit issued[2];
        logic pi, pd;

        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        check_eq("rst_i_grant", bus.i_grant, 1'b0);
        check_eq("rst_d_grant", bus.d_grant, 1'b0);
        check_eq("rst_mem_en", bus.mem_en, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, 16'h0000);
        do_reset();

        // Simultaneous requests straight out of reset: D first, then I right after drain
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        step();
        check_eq("tie_d_first", bus.d_grant, 1'b1);
        check_eq("tie_i_waits", bus.i_grant, 1'b0);
        bus.d_mem_en = 1'b1; bus.d_addr = 16'h0040;
        step();
        bus.d_mem_en = 1'b0; bus.d_req = 1'b0;
        step();
        for (int k = 0; k < LAT; k++) step();
        check_eq("tie_i_after_drain", bus.i_grant, 1'b1);

        // D write-through while I waits behind it
        bus.i_req = 1'b0; bus.d_req = 1'b1;
        step();
        for (int k = 0; k < LAT; k++) step();
        wait_grant(1, 4);
        bus.i_req = 1'b1;
        bus.d_mem_en = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h00F0; bus.d_wdata = 16'hBEEF;
        #1;
        check_eq("wr_mem_wr", bus.mem_wr, 1'b1);
        check_eq("wr_mem_addr", bus.mem_addr, 16'h00F0);
        check_eq("wr_mem_wdata", bus.mem_wdata, 16'hBEEF);
        step();
        bus.d_mem_en = 1'b0; bus.d_wr = 1'b0; bus.d_req = 1'b0;
        step();
        for (int k = 0; k < LAT; k++) step();
        check_eq("wr_i_after_drain", bus.i_grant, 1'b1);

        // Async reset in the middle of a D-cache access
        bus.i_req = 1'b0; bus.d_req = 1'b1;
        step();
        wait_grant(1, 12);
        bus.d_mem_en = 1'b1; bus.d_addr = 16'h0ABC;
        #1;
        check_eq("pre_rst_mem_en", bus.mem_en, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_mem_en", bus.mem_en, 1'b0);
        check_eq("async_rst_d_grant", bus.d_grant, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        model_reset();

        // I-cache alone: 8 reads, release one cycle after the last, D waits through drain
        bus.i_req = 1'b1;
        step();
        check_eq("i_grant_1cyc", bus.i_grant, 1'b1);
        n_idv = 0; n_ddv = 0;
        for (int k = 0; k < 8; k++) begin
            bus.i_mem_en = 1'b1;
            bus.i_addr = 16'h1230 + 16'(2 * k);
            #1;
            check_eq("i_addr_follow", bus.mem_addr, 16'h1230 + 16'(2 * k));
            step();
        end
        bus.i_mem_en = 1'b0; bus.i_req = 1'b0;
        step();
        bus.d_req = 1'b1;
        for (int k = 0; k < LAT; k++) step();
        check_eq("i_valid_pulses", n_idv, 32'd8);
        check_eq("d_valid_none", n_ddv, 32'd0);
        check_eq("d_after_i_drain", bus.d_grant, 1'b1);
        bus.d_req = 1'b0;
        step();
        for (int k = 0; k < LAT; k++) step();

        // Back-to-back contention: grants must alternate starting with D
        do_reset();
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        issued[0] = 1'b0; issued[1] = 1'b0;
        pi = 1'b0; pd = 1'b0;
        for (int n = 0; n < 30; n++) begin
            bus.i_mem_en = (owner == 0) && !issued[0];
            bus.d_mem_en = (owner == 1) && !issued[1];
            bus.i_req = !((owner == 0) && issued[0]);
            bus.d_req = !((owner == 1) && issued[1]);
            if (owner == 0) issued[0] = 1'b1; else issued[0] = 1'b0;
            if (owner == 1) issued[1] = 1'b1; else issued[1] = 1'b0;
            step();
            if (bus.i_grant && !pi) seq.push_back(0);
            if (bus.d_grant && !pd) seq.push_back(1);
            pi = bus.i_grant; pd = bus.d_grant;
        end
        check_eq("rr_count", (seq.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < seq.size(); k++)
            check_eq("rr_order", seq[k], (k % 2 == 0) ? 32'd1 : 32'd0);

        // Random traffic against the model
        do_reset();
        ileft = 0; dleft = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.i_req) begin
                bus.i_mem_en = 1'b0;
                if ($urandom_range(3) == 0) begin bus.i_req = 1'b1; ileft = $urandom_range(1, 4); end
            end else if (owner == 0) begin
                if (ileft == 0) begin bus.i_req = 1'b0; bus.i_mem_en = 1'b0; end
                else begin bus.i_mem_en = ($urandom_range(3) != 0); if (bus.i_mem_en) ileft--; end
            end else begin
                bus.i_mem_en = 1'($urandom_range(1));
            end
            if (!bus.d_req) begin
                bus.d_mem_en = 1'b0;
                if ($urandom_range(3) == 0) begin bus.d_req = 1'b1; dleft = $urandom_range(1, 4); end
            end else if (owner == 1) begin
                if (dleft == 0) begin bus.d_req = 1'b0; bus.d_mem_en = 1'b0; end
                else begin bus.d_mem_en = ($urandom_range(3) != 0); if (bus.d_mem_en) dleft--; end
            end else begin
                bus.d_mem_en = 1'($urandom_range(1));
            end
            bus.d_wr    = 1'($urandom_range(1));
            bus.i_addr  = 16'($urandom);
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 16'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
